// File: rtl/segre_mem_stage.sv
// segre_mem_stage: memory pipeline stage. Issues loads/stores over a req/ready
// port, stalls the front of the pipe while an access is outstanding, and registers writeback.
module segre_mem_stage #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned REG_SIZE  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  logic [1:0]           memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  output logic                 hazard_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic [WORD_SIZE-1:0] mem_rdata_i,
  input  logic                 mem_ready_i,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 misaligned_o
);

  localparam logic [1:0] MEMOP_BYTE = 2'd0;
  localparam logic [1:0] MEMOP_HALF = 2'd1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [1:0]           type_q, type_d;
  logic [1:0]           off_q, off_d;
  logic                 sext_q, sext_d;
  logic [REG_SIZE-1:0]  waddr_q, waddr_d;
  logic                 rf_we_q, rf_we_d;
  logic [REG_SIZE-1:0]  rf_waddr_q, rf_waddr_d;
  logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic                 misaligned_q, misaligned_d;

  logic                 memop_c, misaligned_c, aligned_memop_c, complete_c;
  logic [1:0]           off_c;
  logic [3:0]           in_be_c;
  logic [WORD_SIZE-1:0] in_wdata_c;
  logic [ADDR_SIZE-1:0] in_addr_c;
  logic                 req_c;
  logic [ADDR_SIZE-1:0] cur_addr_c;
  logic [3:0]           cur_be_c;
  logic [WORD_SIZE-1:0] cur_wdata_c;
  logic                 cur_we_c, cur_sext_c;
  logic [1:0]           cur_type_c, cur_off_c;
  logic [REG_SIZE-1:0]  cur_waddr_c;
  logic [15:0]          lane_c;
  logic [WORD_SIZE-1:0] load_c;

  // Decode the incoming EX request: lanes, replicated store data, alignment
  always_comb begin
    off_c        = alu_res_i[1:0];
    memop_c      = memop_rd_i | memop_wr_i;
    in_addr_c    = ADDR_SIZE'({alu_res_i[WORD_SIZE-1:2], 2'b00});
    misaligned_c = 1'b0;
    in_be_c      = 4'b1111;
    in_wdata_c   = rf_st_data_i;
    case (memop_type_i)
      MEMOP_BYTE: begin
        in_be_c    = 4'b0001 << off_c;
        in_wdata_c = WORD_SIZE'({4{rf_st_data_i[7:0]}});
      end
      MEMOP_HALF: begin
        in_be_c      = 4'b0011 << off_c;
        in_wdata_c   = WORD_SIZE'({2{rf_st_data_i[15:0]}});
        misaligned_c = memop_c & off_c[0];
      end
      default: misaligned_c = memop_c & (off_c != 2'b00);
    endcase
    aligned_memop_c = memop_c & ~misaligned_c;
  end

  // Access in flight: live inputs in IDLE, latched copy in WAIT
  always_comb begin
    if (state_q == S_WAIT) begin
      req_c       = 1'b1;
      cur_addr_c  = addr_q;
      cur_be_c    = be_q;
      cur_wdata_c = wdata_q;
      cur_we_c    = we_q;
      cur_type_c  = type_q;
      cur_off_c   = off_q;
      cur_sext_c  = sext_q;
      cur_waddr_c = waddr_q;
    end else begin
      req_c       = aligned_memop_c;
      cur_addr_c  = in_addr_c;
      cur_be_c    = in_be_c;
      cur_wdata_c = in_wdata_c;
      cur_we_c    = memop_wr_i;
      cur_type_c  = memop_type_i;
      cur_off_c   = off_c;
      cur_sext_c  = memop_sign_ext_i;
      cur_waddr_c = rf_waddr_i;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and latch of a request that was not accepted immediately
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    type_d  = type_q;
    off_d   = off_q;
    sext_d  = sext_q;
    waddr_d = waddr_q;
    case (state_q)
      S_IDLE: begin
        if (aligned_memop_c && !mem_ready_i) begin
          state_d = S_WAIT;
          addr_d  = in_addr_c;
          be_d    = in_be_c;
          wdata_d = in_wdata_c;
          we_d    = memop_wr_i;
          type_d  = memop_type_i;
          off_d   = off_c;
          sext_d  = memop_sign_ext_i;
          waddr_d = rf_waddr_i;
        end
      end
      S_WAIT: if (mem_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; reset masks the request combinationally
  always_comb begin
    mem_req_o   = req_c & ~rst_i;
    hazard_o    = mem_req_o & ~mem_ready_i;
    complete_c  = mem_req_o & mem_ready_i;
    mem_we_o    = cur_we_c;
    mem_addr_o  = cur_addr_c;
    mem_be_o    = cur_be_c;
    mem_wdata_o = cur_wdata_c;
  end

  // Load extraction: shift the addressed lane down, then extend
  always_comb begin
    lane_c = 16'(mem_rdata_i >> {cur_off_c, 3'b000});
    case (cur_type_c)
      MEMOP_BYTE: load_c = {{(WORD_SIZE-8){cur_sext_c & lane_c[7]}}, lane_c[7:0]};
      MEMOP_HALF: load_c = {{(WORD_SIZE-16){cur_sext_c & lane_c[15]}}, lane_c[15:0]};
      default:    load_c = mem_rdata_i;
    endcase
  end

  // Writeback selection; stalls, stores and misaligned ops bubble with data held
  always_comb begin
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    misaligned_d = (state_q == S_IDLE) & misaligned_c;
    if (complete_c) begin
      if (!cur_we_c) begin
        rf_we_d    = rf_we_i;
        rf_waddr_d = cur_waddr_c;
        rf_wdata_d = load_c;
      end
    end else if (state_q == S_IDLE && !memop_c) begin
      rf_we_d    = rf_we_i;
      rf_waddr_d = rf_waddr_i;
      rf_wdata_d = alu_res_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      type_q       <= '0;
      off_q        <= '0;
      sext_q       <= 1'b0;
      waddr_q      <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      type_q       <= type_d;
      off_q        <= off_d;
      sext_q       <= sext_d;
      waddr_q      <= waddr_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: doc/segre_mem_stage.md
# segre_mem_stage

Pipeline stage directly downstream of the execute stage. Takes the registered EX results (ALU result / address, store data, memop controls, writeback target). Performs loads and stores over a simple req/ready data-memory interface, and drives a hazard back to the earlier stages while a memory access is outstanding. Registers the writeback triple (we, waddr, wdata) for the WB stage; non-memory results pass through with one cycle of latency.

## Interface
Parameters:
- WORD_SIZE, 32: datapath and memory data width
- ADDR_SIZE, 32: memory address width
- REG_SIZE, 5: register-file address width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- alu_res_i  in  WORD_SIZE  ALU result; byte address when memop_rd_i/memop_wr_i set
- rf_we_i  in  1  writeback enable from EX
- rf_waddr_i  in  REG_SIZE  writeback register
- rf_st_data_i  in  WORD_SIZE  store data (low bits significant)
- memop_type_i  in  2  memop_type_e: BYTE=0, HALF=1, WORD=2 (3 illegal, treated as WORD)
- memop_rd_i  in  1  load
- memop_wr_i  in  1  store (priority over memop_rd_i if both set)
- memop_sign_ext_i  in  1  load sign-extends when 1, zero-extends when 0
- hazard_o  out  1  stall request to IF/ID/EX (combinational)
- mem_req_o  out  1  memory request valid (combinational)
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_SIZE  word-aligned address {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  WORD_SIZE  lane-replicated store data
- mem_rdata_i  in  WORD_SIZE  read word, valid with mem_ready_i
- mem_ready_i  in  1  request accepted/completed this cycle
- rf_we_o  out  1  registered writeback enable
- rf_waddr_o  out  REG_SIZE  registered writeback register
- rf_wdata_o  out  WORD_SIZE  registered writeback data
- misaligned_o  out  1  registered one-cycle pulse on a misaligned memop

## Operation
- memop = memop_rd_i | memop_wr_i. off = alu_res_i[1:0].
- Misaligned: HALF with off[0]=1, or WORD with off!=0. No request is issued, hazard_o=0. Next cycle: misaligned_o=1, rf_we_o=0.
- Byte enables: BYTE → 4'b0001<<off; HALF → 4'b0011<<off; WORD → 4'b1111.
- Store data: BYTE → {4{d[7:0]}}; HALF → {2{d[15:0]}}; WORD → d.
- Load extract: BYTE → rdata byte at lane off; HALF → halfword at lane off[1]; WORD → rdata. Sign- or zero-extend to WORD_SIZE according to memop_sign_ext_i.
- FSM states IDLE, WAIT:
  - IDLE, aligned memop: mem_req_o=1 driven from the inputs. If mem_ready_i=1, the access completes this cycle and the state stays IDLE. Otherwise latch address, be, wdata, we, type, sign_ext and waddr; go to WAIT.
  - WAIT: mem_req_o=1 with the latched values, held stable until mem_ready_i=1. On ready, complete and go to IDLE.
- hazard_o = (IDLE & aligned memop & !mem_ready_i) | (WAIT & !mem_ready_i).
- Output register, updated every cycle:
  - completing load: rf_we_o=rf_we_i, rf_waddr_o=waddr, rf_wdata_o=extracted data
  - completing store: rf_we_o=0
  - non-memop: rf_we_o=rf_we_i, rf_waddr_o=rf_waddr_i, rf_wdata_o=alu_res_i
  - cycle where hazard_o=1, or a misaligned memop: rf_we_o=0 (bubble into WB); rf_waddr_o and rf_wdata_o hold
- misaligned_o is 0 in every cycle not following a misaligned memop.

## Timing
- Reset values: state IDLE; rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, misaligned_o=0.
- While rst_i=1: mem_req_o=0 and hazard_o=0, regardless of inputs.
- Reset during WAIT abandons the request; mem_req_o is 0 from the reset cycle onward. No writeback is produced.
- Non-memop latency: 1 cycle to rf_*_o.
- Memop latency: N+1 cycles, where N = number of cycles with mem_ready_i=0 after request assertion. Zero-wait access: 1 cycle, no stall.
- EX inputs are stable while hazard_o=1; the stage still uses latched values in WAIT.
- mem_ready_i while mem_req_o=0 is ignored.
- Once asserted, mem_req_o is never withdrawn before mem_ready_i, except by reset.

## Test plan
- ALU passthrough: alu_res_i=0x1234, rf_we_i=1, rf_waddr_i=5, no memop → next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; hazard_o=0 throughout.
- Zero-wait signed byte load:
  - stimulus: addr 0x103, BYTE, sign_ext=1, mem_ready_i=1 same cycle, mem_rdata_i=0x80FF_0000
  - required: mem_addr_o=0x100, mem_be_o=0001<<3=4'b1000, no stall; next cycle rf_wdata_o=0xFFFF_FF80
- Waited store:
  - stimulus: HALF store at 0x202, data 0xABCD_5678, mem_ready_i low 3 cycles
  - required: mem_be_o=4'b1100, mem_wdata_o=0x5678_5678, mem_we_o=1; hazard_o=1 for 3 cycles; request fields stable; rf_we_o=0 throughout
- Zero-extended half load: addr 0x2, HALF, sign_ext=0, rdata 0x9ABC_0000 → rf_wdata_o=0x0000_9ABC.
- Misaligned access: WORD load at 0x101 → mem_req_o never asserted; next cycle misaligned_o=1, rf_we_o=0.
- Reset mid-operation: rst_i=1 in the second WAIT cycle → mem_req_o=0 and hazard_o=0 immediately; after release, state IDLE and all outputs at reset values.
